// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control FSM:
// state encoding, ALU operation encoding, opcode and funct7 constants.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } ctrl_state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [6:0] F7_ZERO  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  localparam logic [2:0] F3_WORD  = 3'b010;

  // True for opcodes that go through the MEM state.
  function automatic logic is_mem_op(input logic [6:0] opcode);
    return (opcode == OP_LOAD) || (opcode == OP_STORE);
  endfunction

endpackage

// File: rtl/riscv_alu_dec.sv
// Combinational decoder: opcode/funct3/funct7 -> ALU operation, B-operand
// select and an illegal-instruction flag. Only R-type, I-ALU and word
// LOAD/STORE encodings are legal.
module riscv_alu_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    alu_op,
  output logic       alu_bsel,
  output logic       illegal
);

  // Decode the instruction class, then the operation within the class.
  always_comb begin
    alu_op   = ALU_ADD;
    alu_bsel = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_ZERO) begin
          case (funct3)
            3'b000:  alu_op = ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  alu_op = ALU_SUB;
            3'b101:  alu_op = ALU_SRA;
            default: illegal = 1'b1;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
      OP_I: begin
        alu_bsel = 1'b1;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b110: alu_op = ALU_OR;
          3'b001: begin
            if (funct7 == F7_ZERO) alu_op = ALU_SLL;
            else                   illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_ZERO)     alu_op = ALU_SRL;
            else if (funct7 == F7_ALT) alu_op = ALU_SRA;
            else                       illegal = 1'b1;
          end
          default: alu_op = ALU_AND;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        alu_bsel = 1'b1;
        illegal  = (funct3 != F3_WORD);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control FSM. Sequences FETCH -> DECODE -> EXEC ->
// (MEM) -> (WB) and drives the datapath enables as Moore outputs decoded
// from the state and the latched instruction fields. Illegal encodings
// park the FSM in TRAP until reset.
// Optional build macro RISCV_CTRL_RETIRE_CNT_EN adds retire_cnt_o, a
// wrapping count of pc_we_o pulses.
module riscv_mc_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int IMEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] inst_i,
  input  logic        imem_ready_i,
  input  logic        dmem_ready_i,
  output logic        imem_req_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic        reg_wen_o,
  output logic [3:0]  alu_op_o,
  output logic        alu_bsel_o,
  output logic        wb_sel_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic        trap_o,
  output logic        fetch_err_o
`ifdef RISCV_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt_o
`endif
);

  localparam logic [31:0] TIMEOUT_LIMIT = 32'(IMEM_TIMEOUT);

  ctrl_state_e state;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic [6:0]  funct7_q;
  logic [4:0]  rd_q;
  logic [31:0] wait_cnt;
  logic        fetch_err_q;
  logic        trap_q;

  alu_op_e     dec_op;
  logic        dec_bsel;
  logic        dec_illegal;
  logic        is_load;
  logic        is_store;
  logic        unused_inst_bits;

  // Register-source fields are consumed by the datapath, not by control.
  assign unused_inst_bits = ^inst_i[24:15];

  assign is_load  = (opcode_q == OP_LOAD);
  assign is_store = (opcode_q == OP_STORE);

  riscv_alu_dec u_alu_dec (
    .opcode   (opcode_q),
    .funct3   (funct3_q),
    .funct7   (funct7_q),
    .alu_op   (dec_op),
    .alu_bsel (dec_bsel),
    .illegal  (dec_illegal)
  );

  // State sequencing, field latching, fetch watchdog and sticky flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_FETCH;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      rd_q        <= '0;
      wait_cnt    <= '0;
      fetch_err_q <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready_i) begin
            opcode_q <= inst_i[6:0];
            rd_q     <= inst_i[11:7];
            funct3_q <= inst_i[14:12];
            funct7_q <= inst_i[31:25];
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else if ((IMEM_TIMEOUT != 0) && (wait_cnt != TIMEOUT_LIMIT)) begin
            wait_cnt <= wait_cnt + 32'd1;
            if (wait_cnt + 32'd1 == TIMEOUT_LIMIT) begin
              fetch_err_q <= 1'b1;
            end
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            trap_q <= 1'b1;
            state  <= S_TRAP;
          end else begin
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= is_mem_op(opcode_q) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (dmem_ready_i) begin
            state <= is_load ? S_WB : S_FETCH;
          end
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; the only input-qualified enables are the two
  // handshake-completion strobes ir_we_o and the store's pc_we_o.
  always_comb begin
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    reg_wen_o  = 1'b0;
    alu_op_o   = ALU_ADD;
    alu_bsel_o = 1'b0;
    wb_sel_o   = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req_o = !rst_i;
        ir_we_o    = !rst_i && imem_ready_i;
      end
      S_EXEC: begin
        alu_op_o   = dec_op;
        alu_bsel_o = dec_bsel;
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store;
        alu_op_o   = ALU_ADD;
        alu_bsel_o = 1'b1;
        pc_we_o    = is_store && dmem_ready_i;
      end
      S_WB: begin
        alu_op_o   = dec_op;
        alu_bsel_o = dec_bsel;
        reg_wen_o  = (rd_q != 5'd0);
        wb_sel_o   = is_load;
        pc_we_o    = 1'b1;
      end
      default: begin
        imem_req_o = 1'b0;
      end
    endcase
  end

  assign trap_o      = trap_q;
  assign fetch_err_o = fetch_err_q;

`ifdef RISCV_CTRL_RETIRE_CNT_EN
  // Count retired instructions; wraps naturally at 32 bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retire_cnt_o <= '0;
    end else if (pc_we_o) begin
      retire_cnt_o <= retire_cnt_o + 32'd1;
    end
  end
`else
  // No retire counter in this build.
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: each driven cycle pushes the
// expected output vector, a negedge monitor pops and compares it.
module tb_riscv_mc_ctrl;

  localparam int K_R     = 0;
  localparam int K_I     = 1;
  localparam int K_LOAD  = 2;
  localparam int K_STORE = 3;
  localparam int K_ILL   = 4;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       pc_we;
    logic       reg_wen;
    logic [3:0] alu_op;
    logic       alu_bsel;
    logic       wb_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       trap;
  } exp_t;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] inst_i;
  logic        imem_ready_i;
  logic        dmem_ready_i;
  logic        imem_req_o;
  logic        ir_we_o;
  logic        pc_we_o;
  logic        reg_wen_o;
  logic [3:0]  alu_op_o;
  logic        alu_bsel_o;
  logic        wb_sel_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        trap_o;
  logic        fetch_err_o;
`ifdef RISCV_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt_o;
`endif

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   retired      = 0;

  riscv_mc_ctrl #(.IMEM_TIMEOUT(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inst_i       (inst_i),
    .imem_ready_i (imem_ready_i),
    .dmem_ready_i (dmem_ready_i),
    .imem_req_o   (imem_req_o),
    .ir_we_o      (ir_we_o),
    .pc_we_o      (pc_we_o),
    .reg_wen_o    (reg_wen_o),
    .alu_op_o     (alu_op_o),
    .alu_bsel_o   (alu_bsel_o),
    .wb_sel_o     (wb_sel_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .trap_o       (trap_o),
    .fetch_err_o  (fetch_err_o)
`ifdef RISCV_CTRL_RETIRE_CNT_EN
    ,
    .retire_cnt_o (retire_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, actual, expected);
    end
  endtask

  // Compare the DUT against the oldest expected vector, mid-cycle.
  always @(negedge clk_i) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("imem_req", 32'(imem_req_o), 32'(e.imem_req));
      checkOutput("ir_we",    32'(ir_we_o),    32'(e.ir_we));
      checkOutput("pc_we",    32'(pc_we_o),    32'(e.pc_we));
      checkOutput("reg_wen",  32'(reg_wen_o),  32'(e.reg_wen));
      checkOutput("alu_op",   32'(alu_op_o),   32'(e.alu_op));
      checkOutput("alu_bsel", 32'(alu_bsel_o), 32'(e.alu_bsel));
      checkOutput("wb_sel",   32'(wb_sel_o),   32'(e.wb_sel));
      checkOutput("dmem_req", 32'(dmem_req_o), 32'(e.dmem_req));
      checkOutput("dmem_we",  32'(dmem_we_o),  32'(e.dmem_we));
      checkOutput("trap",     32'(trap_o),     32'(e.trap));
    end
  end

  task automatic driveCycle(input logic imem_rdy, input logic dmem_rdy,
                            input logic [31:0] inst, input exp_t e);
    imem_ready_i = imem_rdy;
    dmem_ready_i = dmem_rdy;
    inst_i       = inst;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_imem_req"},  32'(imem_req_o),  32'd0);
    checkOutput({tag, "_pc_we"},     32'(pc_we_o),     32'd0);
    checkOutput({tag, "_reg_wen"},   32'(reg_wen_o),   32'd0);
    checkOutput({tag, "_dmem_req"},  32'(dmem_req_o),  32'd0);
    checkOutput({tag, "_alu_op"},    32'(alu_op_o),    32'd0);
    checkOutput({tag, "_trap"},      32'(trap_o),      32'd0);
    checkOutput({tag, "_fetch_err"}, 32'(fetch_err_o), 32'd0);
`ifdef RISCV_CTRL_RETIRE_CNT_EN
    checkOutput({tag, "_retire"},    retire_cnt_o,     32'd0);
`endif
  endtask

  task automatic doReset();
    rst_i        = 1'b1;
    imem_ready_i = 1'b0;
    dmem_ready_i = 1'b0;
    #1;
    checkResetState("rst");
    repeat (2) @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    retired = 0;
    #1;
    checkOutput("rst_release_imem_req", 32'(imem_req_o), 32'd1);
  endtask

  // Run one instruction through the FSM, pushing the expected vector
  // for every cycle it occupies.
  task automatic applyStimulus(input logic [31:0] inst, input int kind,
                               input logic [3:0] op, input logic bsel,
                               input logic rd_zero, input int dmem_wait,
                               input int hold);
    exp_t e;
    e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
    driveCycle(1'b1, 1'b0, inst, e);
    e = '0;
    driveCycle(1'b0, 1'b0, 32'hDEAD_BEEF, e);
    if (kind == K_ILL) begin
      for (int i = 0; i < hold; i++) begin
        e = '0; e.trap = 1'b1;
        driveCycle(1'b0, 1'b0, 32'hDEAD_BEEF, e);
      end
      return;
    end
    e = '0; e.alu_op = op; e.alu_bsel = bsel;
    driveCycle(1'b0, 1'b0, 32'hDEAD_BEEF, e);
    if (kind == K_LOAD || kind == K_STORE) begin
      for (int i = 0; i < dmem_wait; i++) begin
        e = '0; e.dmem_req = 1'b1; e.dmem_we = (kind == K_STORE); e.alu_bsel = 1'b1;
        driveCycle(1'b0, 1'b0, 32'hDEAD_BEEF, e);
      end
      e = '0; e.dmem_req = 1'b1; e.dmem_we = (kind == K_STORE); e.alu_bsel = 1'b1;
      e.pc_we = (kind == K_STORE);
      driveCycle(1'b0, 1'b1, 32'hDEAD_BEEF, e);
      if (kind == K_STORE) begin
        retired++;
        return;
      end
    end
    e = '0; e.reg_wen = !rd_zero; e.wb_sel = (kind == K_LOAD); e.pc_we = 1'b1;
    e.alu_op = op; e.alu_bsel = bsel;
    driveCycle(1'b0, 1'b0, 32'hDEAD_BEEF, e);
    retired++;
  endtask

  initial begin
    exp_t e;
    rst_i        = 1'b1;
    inst_i       = '0;
    imem_ready_i = 1'b0;
    dmem_ready_i = 1'b0;
    doReset();

    applyStimulus(32'h002081B3, K_R,     4'd0, 1'b0, 1'b0, 0, 0);  // ADD x3,x1,x2
    applyStimulus(32'h402081B3, K_R,     4'd1, 1'b0, 1'b0, 0, 0);  // SUB
    applyStimulus(32'h4032D293, K_I,     4'd7, 1'b1, 1'b0, 0, 0);  // SRAI x5,x5,3
    applyStimulus(32'h0020C1B3, K_R,     4'd5, 1'b0, 1'b0, 0, 0);  // XOR
    applyStimulus(32'hFFF13093, K_I,     4'd4, 1'b1, 1'b0, 0, 0);  // SLTIU x1,x2,-1
    applyStimulus(32'h0080A203, K_LOAD,  4'd0, 1'b1, 1'b0, 3, 0);  // LW, 3 wait cycles
    applyStimulus(32'h0040A423, K_STORE, 4'd0, 1'b1, 1'b0, 0, 0);  // SW
    applyStimulus(32'h00100013, K_I,     4'd0, 1'b1, 1'b1, 0, 0);  // ADDI x0,x0,1
    applyStimulus(32'h0080A203, K_LOAD,  4'd0, 1'b1, 1'b0, 0, 0);  // LW, zero wait
`ifdef RISCV_CTRL_RETIRE_CNT_EN
    checkOutput("retire_cnt", retire_cnt_o, 32'(retired));
`endif

    applyStimulus(32'h0000006F, K_ILL,   4'd0, 1'b0, 1'b0, 0, 20); // JAL traps
`ifdef RISCV_CTRL_RETIRE_CNT_EN
    checkOutput("retire_cnt_trap", retire_cnt_o, 32'(retired));
`endif
    doReset();
    applyStimulus(32'h022081B3, K_ILL,   4'd0, 1'b0, 1'b0, 0, 3);  // MUL funct7
    doReset();
    applyStimulus(32'h00809203, K_ILL,   4'd0, 1'b0, 1'b0, 0, 3);  // LH width
    doReset();
    applyStimulus(32'h40109093, K_ILL,   4'd0, 1'b0, 1'b0, 0, 3);  // SLLI bad funct7
    doReset();
    applyStimulus(32'h00109093, K_I,     4'd2, 1'b1, 1'b0, 0, 0);  // SLLI x1,x1,1

    for (int i = 0; i < 15; i++) begin
      e = '0; e.imem_req = 1'b1;
      driveCycle(1'b0, 1'b0, 32'h0, e);
    end
    checkOutput("fetch_err_15", 32'(fetch_err_o), 32'd0);
    e = '0; e.imem_req = 1'b1;
    driveCycle(1'b0, 1'b0, 32'h0, e);
    checkOutput("fetch_err_16", 32'(fetch_err_o), 32'd1);

    e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
    driveCycle(1'b1, 1'b0, 32'h0080A203, e);
    e = '0;
    driveCycle(1'b0, 1'b0, 32'h0, e);
    e = '0; e.alu_bsel = 1'b1;
    driveCycle(1'b0, 1'b0, 32'h0, e);
    e = '0; e.dmem_req = 1'b1; e.alu_bsel = 1'b1;
    driveCycle(1'b0, 1'b0, 32'h0, e);
    driveCycle(1'b0, 1'b0, 32'h0, e);
    checkOutput("mem_before_rst", 32'(dmem_req_o), 32'd1);
    checkOutput("fetch_err_sticky", 32'(fetch_err_o), 32'd1);
    rst_i = 1'b1;
    #1;
    checkOutput("mem_rst_dmem_req", 32'(dmem_req_o), 32'd0);
    checkOutput("mem_rst_reg_wen",  32'(reg_wen_o),  32'd0);
    checkOutput("mem_rst_fetch_err", 32'(fetch_err_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    retired = 0;
    #1;
    checkOutput("after_rst_imem_req", 32'(imem_req_o), 32'd1);
`ifdef RISCV_CTRL_RETIRE_CNT_EN
    checkOutput("after_rst_retire", retire_cnt_o, 32'd0);
`endif
    applyStimulus(32'h002081B3, K_R, 4'd0, 1'b0, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
